// File: rtl/b23_pkg.sv
// Shared constants and FSM encoding for the b23 bias controller.
package b23_pkg;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2,
    STREAM = 2'd3
  } state_t;

endpackage

// File: rtl/b23_bias_ctrl_if.sv
// Loader, layer-engine stream and external bias-memory signals of the bias controller.
// master = the controller, slave = its surroundings (loader, engine, memory).
interface b23_bias_ctrl_if #(
  parameter int DW = b23_pkg::DW,
  parameter int AW = b23_pkg::AW
) ();

  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          reload;
  logic          start;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic          loaded;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_wraddr;
  logic [DW-1:0] mem_wrdata;
  logic          mem_rd;
  logic [AW-1:0] mem_rdaddr;
  logic [DW-1:0] mem_rddata;

  modport master (
    input  ld_valid, ld_data, reload, start, out_ready, mem_rddata,
    output ld_ready, out_valid, out_data, out_idx, out_last, loaded, busy,
           mem_we, mem_wraddr, mem_wrdata, mem_rd, mem_rdaddr
  );

  modport slave (
    output ld_valid, ld_data, reload, start, out_ready, mem_rddata,
    input  ld_ready, out_valid, out_data, out_idx, out_last, loaded, busy,
           mem_we, mem_wraddr, mem_wrdata, mem_rd, mem_rdaddr
  );

endinterface

// File: rtl/b23_bias_ctrl.sv
// Loads DEPTH signed biases into external memory, then streams them 0..DEPTH-1 on start.
// Writes are combinational with the load handshake; start-to-valid is 1 cycle; stream stalls hold on out_ready=0.
module b23_bias_ctrl #(
  parameter int DW    = b23_pkg::DW,
  parameter int AW    = b23_pkg::AW,
  parameter int DEPTH = b23_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  b23_bias_ctrl_if.master  bus
);

  import b23_pkg::*;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] out_idx_q;
  logic [DW-1:0] out_data_q;
  logic          loaded_q;
  logic          out_valid_q;

  logic ld_rdy, reload_ok, ld_xfer, wr_last, start_ok, out_xfer, out_last, rd_next;

  assign ld_rdy    = (state_q == IDLE) || (state_q == LOAD);
  assign reload_ok = bus.reload && (state_q != STREAM);
  // A reload wins over a same-cycle load word: the word is dropped, not written.
  assign ld_xfer   = bus.ld_valid && ld_rdy && !reload_ok;
  assign wr_last   = (wr_ptr == LAST);
  assign start_ok  = bus.start && (state_q == LOADED) && !bus.reload;
  assign out_xfer  = out_valid_q && bus.out_ready;
  assign out_last  = out_valid_q && (out_idx_q == LAST);
  assign rd_next   = out_xfer && !out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: begin
        if (reload_ok)                state_d = LOAD;
        else if (ld_xfer && wr_last)  state_d = LOADED;
        else if (ld_xfer)             state_d = LOAD;
      end
      LOADED: begin
        if (reload_ok)      state_d = LOAD;
        else if (start_ok)  state_d = STREAM;
      end
      STREAM: begin
        if (out_xfer && out_last) state_d = LOADED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      if (reload_ok) begin
        wr_ptr   <= '0;
        loaded_q <= 1'b0;
      end else if (ld_xfer) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        if (wr_last) loaded_q <= 1'b1;
      end

      if (start_ok)                   out_valid_q <= 1'b1;
      else if (out_xfer && out_last)  out_valid_q <= 1'b0;

      if (start_ok)      out_idx_q <= '0;
      else if (rd_next)  out_idx_q <= out_idx_q + 1'b1;

      // Memory read data is captured in the same cycle the read is issued.
      if (bus.mem_rd) out_data_q <= bus.mem_rddata;
    end
  end

  always_comb begin
    bus.mem_rd     = 1'b0;
    bus.mem_rdaddr = '0;
    if (start_ok) begin
      bus.mem_rd = 1'b1;
    end else if (rd_next) begin
      bus.mem_rd     = 1'b1;
      bus.mem_rdaddr = out_idx_q + 1'b1;
    end
  end

  assign bus.mem_we     = ld_xfer;
  assign bus.mem_wraddr = ld_xfer ? wr_ptr : '0;
  assign bus.mem_wrdata = ld_xfer ? bus.ld_data : '0;

  assign bus.ld_ready  = ld_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last;
  assign bus.loaded    = loaded_q;
  assign bus.busy      = (state_q == LOAD) || (state_q == STREAM);

endmodule

// File: tb/tb_b23_bias_ctrl.sv
// Directed and randomized bench for b23_bias_ctrl with an external memory model and expected-word arrays.
module tb_b23_bias_ctrl;

  import b23_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  b23_bias_ctrl_if bif ();

  b23_bias_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // External bias memory: synchronous write, combinational read gated by mem_rd.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) if (bif.mem_we) mem[bif.mem_wraddr] <= bif.mem_wrdata;
  assign bif.mem_rddata = bif.mem_rd ? mem[bif.mem_rdaddr] : '0;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] w_inc  [DEPTH];
  logic [DW-1:0] w_neg  [DEPTH];
  logic [DW-1:0] w_rnd  [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers words w[first..n-1]; expects each write at the address equal to its position.
  task automatic load_words(input int first, input int n, input int gap_pct,
                            input logic [DW-1:0] w [DEPTH]);
    int i;
    int guard;
    i = first;
    guard = 0;
    while (i < n && guard < 500) begin
      guard++;
      if ($urandom_range(99) < gap_pct) begin
        bif.ld_valid = 1'b0;
        @(negedge clk);
        chk("we_idle", 32'(bif.mem_we), 0);
      end else begin
        bif.ld_valid = 1'b1;
        bif.ld_data  = w[i];
        @(negedge clk);
        chk("ld_ready", 32'(bif.ld_ready), 1);
        chk("mem_we", 32'(bif.mem_we), 1);
        chk("wraddr", 32'(bif.mem_wraddr), i);
        chk("wrdata", 32'(bif.mem_wrdata), 32'(w[i]));
        i++;
      end
      tick();
    end
    bif.ld_valid = 1'b0;
    if (guard >= 500) chk("load_timeout", 0, 1);
  endtask

  task automatic expect_status(input string tag, input int exp_loaded, input int exp_busy);
    @(negedge clk);
    chk({tag, "_loaded"}, 32'(bif.loaded), exp_loaded);
    chk({tag, "_busy"}, 32'(bif.busy), exp_busy);
    chk({tag, "_ovalid"}, 32'(bif.out_valid), 0);
    tick();
  endtask

  task automatic reload_pulse();
    bif.reload = 1'b1;
    tick();
    bif.reload = 1'b0;
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
  task automatic stream(input int mode, input int reload_at, input logic [DW-1:0] exp_w [DEPTH]);
    int  k;
    int  cyc;
    logic r;
    k = 0;
    cyc = 0;
    bif.start = 1'b1;
    @(negedge clk);
    chk("start_rd", 32'(bif.mem_rd), 1);
    chk("start_rdaddr", 32'(bif.mem_rdaddr), 0);
    chk("start_ovalid", 32'(bif.out_valid), 0);
    tick();
    bif.start = 1'b0;
    while (k < DEPTH && cyc < 300) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom_range(1));
      endcase
      bif.out_ready = r;
      bif.reload    = (cyc == reload_at);
      @(negedge clk);
      chk("out_valid", 32'(bif.out_valid), 1);
      chk("out_idx", 32'(bif.out_idx), k);
      chk("out_data", 32'(bif.out_data), 32'(exp_w[k]));
      chk("out_last", 32'(bif.out_last), 32'(k == DEPTH - 1));
      if (r) begin
        chk("rd_next", 32'(bif.mem_rd), 32'(k != DEPTH - 1));
        chk("rd_addr", 32'(bif.mem_rdaddr), (k != DEPTH - 1) ? k + 1 : 0);
        k++;
      end else begin
        chk("rd_stall", 32'(bif.mem_rd), 0);
      end
      tick();
      cyc++;
    end
    bif.out_ready = 1'b0;
    bif.reload    = 1'b0;
    if (cyc >= 300) chk("stream_timeout", 0, 1);
    expect_status("post_stream", 1, 0);
  endtask

  initial begin
    bif.ld_valid  = 1'b0;
    bif.ld_data   = '0;
    bif.reload    = 1'b0;
    bif.start     = 1'b0;
    bif.out_ready = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      w_inc[j] = DW'(j + 1);
      w_neg[j] = DW'(j - 10);
    end

    #12;
    chk("rst_ld_ready", 32'(bif.ld_ready), 1);
    chk("rst_out_valid", 32'(bif.out_valid), 0);
    chk("rst_loaded", 32'(bif.loaded), 0);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_mem_we", 32'(bif.mem_we), 0);
    chk("rst_mem_rd", 32'(bif.mem_rd), 0);
    chk("rst_out_data", 32'(bif.out_data), 0);
    chk("rst_out_idx", 32'(bif.out_idx), 0);
    chk("rst_out_last", 32'(bif.out_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // start in IDLE is ignored
    bif.start = 1'b1;
    @(negedge clk);
    chk("idle_start_rd", 32'(bif.mem_rd), 0);
    tick();
    bif.start = 1'b0;
    expect_status("idle_start", 0, 0);

    // start after 5 loaded words is ignored
    load_words(0, 5, 0, w_inc);
    bif.start = 1'b1;
    @(negedge clk);
    chk("load_start_rd", 32'(bif.mem_rd), 0);
    tick();
    bif.start = 1'b0;
    expect_status("load_start", 0, 1);
    load_words(5, DEPTH, 30, w_inc);
    expect_status("loaded_a", 1, 0);
    stream(0, -1, w_inc);

    // reload from LOADED clears loaded and re-enters LOAD
    reload_pulse();
    expect_status("reload_loaded", 0, 1);

    // reload with a same-cycle load word drops the word
    load_words(0, 3, 0, w_neg);
    bif.reload   = 1'b1;
    bif.ld_valid = 1'b1;
    bif.ld_data  = 16'h5A5A;
    @(negedge clk);
    chk("reload_drop_we", 32'(bif.mem_we), 0);
    tick();
    bif.reload   = 1'b0;
    bif.ld_valid = 1'b0;

    // ten back-to-back writes, then stall-pattern stream, then stream with ignored reload
    load_words(0, DEPTH, 0, w_inc);
    expect_status("loaded_b", 1, 0);
    stream(1, -1, w_inc);
    stream(0, 4, w_inc);

    for (int round = 0; round < 3; round++) begin
      for (int j = 0; j < DEPTH; j++) w_rnd[j] = DW'($urandom);
      reload_pulse();
      load_words(0, DEPTH, 30, w_rnd);
      expect_status("loaded_rnd", 1, 0);
      stream(2, int'($urandom_range(0, 8)), w_rnd);
    end

    // reset while the sixth word is offered aborts the load
    reload_pulse();
    load_words(0, 5, 0, w_inc);
    bif.ld_valid = 1'b1;
    bif.ld_data  = w_inc[5];
    rst = 1'b1;
    bif.ld_valid = 1'b0;
    @(negedge clk);
    chk("midrst_loaded", 32'(bif.loaded), 0);
    chk("midrst_ld_ready", 32'(bif.ld_ready), 1);
    chk("midrst_busy", 32'(bif.busy), 0);
    tick();
    rst = 1'b0;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    expect_status("postrst_start", 0, 0);

    reload_pulse();
    load_words(0, DEPTH, 20, w_neg);
    expect_status("loaded_neg", 1, 0);
    stream(2, -1, w_neg);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
